matrix_crc_tx_framer: RTL

//  Transmit-side CRC framer for reader->tag commands (EPC Gen2). Accepts MSB-aligned command words,

---
 rtl/matrix_crc_tx_framer_pkg.sv | 27 ++
 rtl/matrix_crc_tx_lfsr.sv | 37 +++
 rtl/matrix_crc_tx_framer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/matrix_crc_tx_framer_pkg.sv
// Shared constants for the Gen2 transmit CRC framer: CRC presets and polynomials,
// CrcMode codes, CRC lengths and FSM state codes.
// The CRC5 constants exist only when MATRIX_CRC5_EN is defined.
package matrix_crc_tx_framer_pkg;

  localparam logic [15:0] Crc16Preset = 16'hFFFF;
  localparam logic [15:0] Crc16Poly   = 16'h1021;
  localparam logic [5:0]  Crc16Len    = 6'd16;

`ifdef MATRIX_CRC5_EN
  localparam logic [4:0]  Crc5Preset  = 5'b01001;
  localparam logic [4:0]  Crc5Poly    = 5'b01001;
  localparam logic [5:0]  Crc5Len     = 6'd5;
`endif

  localparam logic [1:0]  ModeNone    = 2'b00;
  localparam logic [1:0]  ModeCrc16   = 2'b01;
  localparam logic [1:0]  ModeCrc5    = 2'b10;
  localparam logic [1:0]  ModeRsvd    = 2'b11;

  localparam logic [2:0]  StIdle      = 3'd0;
  localparam logic [2:0]  StLoad      = 3'd1;
  localparam logic [2:0]  StShift     = 3'd2;
  localparam logic [2:0]  StCrc       = 3'd3;
  localparam logic [2:0]  StDone      = 3'd4;

endpackage

// File: rtl/matrix_crc_tx_lfsr.sv
// Serial MSB-first CRC LFSR of selectable width.
// The shift enable holds the register when low. When the feedback gate is
// low the register only shifts left, which is how the CRC is shifted out.
module matrix_crc_tx_lfsr #(
  parameter int Width = 16,
  parameter logic [Width-1:0] Poly = 16'h1021,
  parameter logic [Width-1:0] PresetVal = 16'hFFFF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             PresetEn,
  input  logic             ShiftEn,
  input  logic             FbEn,
  input  logic             DataIn,
  output logic [Width-1:0] Crc,
  output logic [Width-1:0] CrcNext
);

  logic feedback;

  // Value the register takes on the next enabled shift
  always_comb begin
    feedback = FbEn & (Crc[Width-1] ^ DataIn);
    CrcNext  = {Crc[Width-2:0], 1'b0} ^ (feedback ? Poly : '0);
  end

  // Preset wins over a shift; otherwise hold unless enabled
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      Crc <= PresetVal;
    else if (PresetEn)
      Crc <= PresetVal;
    else if (ShiftEn)
      Crc <= CrcNext;
  end

endmodule

// File: rtl/matrix_crc_tx_framer.sv
// Gen2 reader->tag transmit framer: serialises MSB-aligned command words MSB-first
// and appends CRC16 (complemented) or CRC5 (uncomplemented).
// Build option: MATRIX_CRC5_EN adds the CRC5 LFSR and makes CrcMode 10 legal.
//
// state   | meaning
// IDLE    | no frame; waits for FrameStart
// LOAD    | WordReady high, waiting for the next data word
// SHIFT   | sending data bits from the shift register
// CRC     | sending CRC bits
// DONE    | TxDone pulse, TxCrc updated
module matrix_crc_tx_framer
  import matrix_crc_tx_framer_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        FrameStart,
  input  logic [1:0]  CrcMode,
  input  logic        FrameAbort,
  input  logic [31:0] WordData,
  input  logic [5:0]  WordBitCnt,
  input  logic        WordLast,
  input  logic        WordValid,
  output logic        WordReady,
  output logic        TxBit,
  output logic        TxBitValid,
  input  logic        TxBitReady,
  output logic        TxBusy,
  output logic        TxDone,
  output logic        ModeErr,
  output logic [15:0] TxCrc
);

  logic [2:0]  state;
  logic [1:0]  mode;
  logic [31:0] shreg;
  logic [5:0]  bitCnt;
  logic        lastWord;
  logic [15:0] finalCrc;
  logic        modeLegal;
  logic [5:0]  wordLen;
  logic        presetEn;
  logic        shiftAcc;
  logic        crcAcc;
  logic [15:0] crc16Val;
  logic [15:0] crc16Next;

  // Mode legality and word length decode
  always_comb begin
`ifdef MATRIX_CRC5_EN
    modeLegal = (CrcMode != ModeRsvd);
`else
    modeLegal = (CrcMode == ModeNone) || (CrcMode == ModeCrc16);
`endif
    wordLen  = ((WordBitCnt == 6'd0) || (WordBitCnt > 6'd32)) ? 6'd32 : WordBitCnt;
    presetEn = (state == StIdle) && FrameStart && modeLegal;
    shiftAcc = (state == StShift) && TxBitReady && !FrameAbort;
    crcAcc   = (state == StCrc) && TxBitReady && !FrameAbort;
  end

  matrix_crc_tx_lfsr #(.Width(16), .Poly(Crc16Poly), .PresetVal(Crc16Preset)) uCrc16 (
    .Clk     (Clk),
    .Reset   (Reset),
    .PresetEn(presetEn),
    .ShiftEn (shiftAcc || (crcAcc && (mode == ModeCrc16))),
    .FbEn    (state == StShift),
    .DataIn  (shreg[31]),
    .Crc     (crc16Val),
    .CrcNext (crc16Next)
  );

`ifdef MATRIX_CRC5_EN
  logic [4:0] crc5Val;
  logic [4:0] crc5Next;

  matrix_crc_tx_lfsr #(.Width(5), .Poly(Crc5Poly), .PresetVal(Crc5Preset)) uCrc5 (
    .Clk     (Clk),
    .Reset   (Reset),
    .PresetEn(presetEn),
    .ShiftEn (shiftAcc || (crcAcc && (mode == ModeCrc5))),
    .FbEn    (state == StShift),
    .DataIn  (shreg[31]),
    .Crc     (crc5Val),
    .CrcNext (crc5Next)
  );
`endif

  // Frame sequencing; abort outranks every handshake
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= StIdle;
      mode     <= ModeNone;
      shreg    <= '0;
      bitCnt   <= '0;
      lastWord <= 1'b0;
      finalCrc <= '0;
      TxCrc    <= '0;
      ModeErr  <= 1'b0;
    end else if (FrameAbort && (state != StIdle)) begin
      state  <= StIdle;
      bitCnt <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (FrameStart) begin
            if (modeLegal) begin
              mode    <= CrcMode;
              ModeErr <= 1'b0;
              state   <= StLoad;
            end else begin
              ModeErr <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (WordValid) begin
            shreg    <= WordData;
            bitCnt   <= wordLen;
            lastWord <= WordLast;
            state    <= StShift;
          end
        end
        StShift: begin
          if (TxBitReady) begin
            shreg <= {shreg[30:0], 1'b0};
            if (bitCnt == 6'd1) begin
              if (!lastWord) begin
                bitCnt <= '0;
                state  <= StLoad;
              end else begin
                // Capture the CRC now: shifting it out clears the LFSR
`ifdef MATRIX_CRC5_EN
                finalCrc <= (mode == ModeCrc5) ? {11'd0, crc5Next} : crc16Next;
`else
                finalCrc <= crc16Next;
`endif
                if (mode == ModeNone) begin
                  bitCnt <= '0;
                  state  <= StDone;
                end else begin
`ifdef MATRIX_CRC5_EN
                  bitCnt <= (mode == ModeCrc5) ? Crc5Len : Crc16Len;
`else
                  bitCnt <= Crc16Len;
`endif
                  state  <= StCrc;
                end
              end
            end else begin
              bitCnt <= bitCnt - 6'd1;
            end
          end
        end
        StCrc: begin
          if (TxBitReady) begin
            bitCnt <= bitCnt - 6'd1;
            if (bitCnt == 6'd1)
              state <= StDone;
          end
        end
        StDone: begin
          TxCrc <= finalCrc;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Serial bit selection and status decode
  always_comb begin
    TxBit = 1'b0;
    case (state)
      StShift: TxBit = shreg[31];
      StCrc: begin
`ifdef MATRIX_CRC5_EN
        TxBit = (mode == ModeCrc5) ? crc5Val[4] : ~crc16Val[15];
`else
        TxBit = ~crc16Val[15];
`endif
      end
      default: TxBit = 1'b0;
    endcase
    TxBitValid = (state == StShift) || (state == StCrc);
    WordReady  = (state == StLoad);
    TxBusy     = (state != StIdle);
    TxDone     = (state == StDone);
  end

endmodule
